// File: rtl/ex_hilo_muldiv.sv
// ex_hilo_muldiv: EX-stage HI/LO register pair with single-cycle multiply,
// 32-step iterative restoring divide, MTHI/MTLO writes and MFHI/MFLO read mux.
module ex_hilo_muldiv #(
   parameter int DIV_STEPS = 32
) (
   input  logic        cpu_clk,
   input  logic        reset,
   input  logic        cancel,
   input  logic        start,
   input  logic [5:0]  func,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        mfhi,
   input  logic        mflo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_result,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DIV  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_DIV   = 6'h1A;
   localparam logic [5:0] FUNC_DIVU  = 6'h1B;

   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   logic [1:0]  state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] dvd_q, dvd_d;      // dividend; quotient bits shift in at the bottom
   logic [31:0] dvs_q, dvs_d;      // divisor magnitude
   logic [31:0] rem_q, rem_d;      // partial remainder (always < divisor)
   logic [31:0] raw_a_q, raw_a_d;  // unmodified dividend for the divide-by-zero result
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic [63:0] prod_s, prod_u;
   logic [32:0] rem_shift, rem_diff;
   logic        rem_ge;
   logic        is_mult, is_div, div_signed;

   // Full 64-bit products; operands pre-extended so the result is exact.
   assign prod_s = {{32{dataA[31]}}, dataA} * {{32{dataB[31]}}, dataB};
   assign prod_u = {32'd0, dataA} * {32'd0, dataB};

   // One restoring step: shift in the next dividend bit and trial-subtract.
   // A borrow out of bit 32 means the shifted remainder was below the divisor.
   assign rem_shift = {rem_q, dvd_q[31]};
   assign rem_diff  = rem_shift - {1'b0, dvs_q};
   assign rem_ge    = ~rem_diff[32];

   assign is_mult    = (func == FUNC_MULT) || (func == FUNC_MULTU);
   assign is_div     = (func == FUNC_DIV)  || (func == FUNC_DIVU);
   assign div_signed = (func == FUNC_DIV);

   // Next-state logic for the divide FSM, datapath and HI/LO registers.
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      count_d = count_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      raw_a_d = raw_a_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cancel) begin
               // Flush in EX: drop this cycle's start/mthi/mtlo.
            end else if (start && is_mult) begin
               {hi_d, lo_d} = (func == FUNC_MULTU) ? prod_u : prod_s;
            end else if (start && is_div) begin
               dvd_d   = (div_signed && dataA[31]) ? (32'd0 - dataA) : dataA;
               dvs_d   = (div_signed && dataB[31]) ? (32'd0 - dataB) : dataB;
               q_neg_d = div_signed && (dataA[31] ^ dataB[31]);
               r_neg_d = div_signed && dataA[31];
               raw_a_d = dataA;
               rem_d   = 32'd0;
               count_d = 5'd0;
               state_d = ST_DIV;
            end else begin
               if (mthi) hi_d = dataA;
               if (mtlo) lo_d = dataA;
            end
         end

         ST_DIV: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               rem_d   = rem_ge ? rem_diff[31:0] : rem_shift[31:0];
               dvd_d   = {dvd_q[30:0], rem_ge};
               count_d = count_q + 5'd1;
               if (count_q == LAST_STEP) state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            state_d = ST_IDLE;
            if (!cancel) begin
               if (dvs_q == 32'd0) begin
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = raw_a_q;
               end else begin
                  lo_d = q_neg_q ? (32'd0 - dvd_q) : dvd_q;
                  hi_d = r_neg_q ? (32'd0 - rem_q) : rem_q;
               end
               done_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset clears everything, aborting any divide in flight.
   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= 5'd0;
         dvd_q   <= 32'd0;
         dvs_q   <= 32'd0;
         rem_q   <= 32'd0;
         raw_a_q <= 32'd0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q <= state_d;
         count_q <= count_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         raw_a_q <= raw_a_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // LO is the default read source, so mflo carries no extra information.
   logic unused_mflo;
   assign unused_mflo = mflo;

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign mf_result = mfhi ? hi_q : lo_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule

// File: doc/ex_hilo_muldiv.md
# ex_hilo_muldiv

- Owns the architectural HI/LO register pair.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO and supplies MFHI/MFLO read data, all in the EX stage.
- Consumes operands and decoded controls from the ID/EX pipeline register.
- Multiplies complete in one cycle; divides run on an iterative 32-step restoring divider and hold `busy` so hazard control can stall the front of the pipeline.

## Interface
Parameters:
- `DIV_STEPS`, 32: quotient bits produced, one per cycle; fixed at 32.

Ports:
- `cpu_clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `cancel`  in  1  pipeline flush; aborts an in-flight divide.
- `start`  in  1  valid MULT/MULTU/DIV/DIVU in EX this cycle.
- `func`  in  6  instruction func field: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- `dataA`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `dataB`  in  32  rt operand (divisor / multiplier).
- `mthi`, `mtlo`  in  1 each  write HI / LO with `dataA`.
- `mfhi`, `mflo`  in  1 each  select HI / LO onto `mf_result`.
- `hi`, `lo`  out  32 each  current HI / LO register contents.
- `mf_result`  out  32  `mfhi ? hi : lo`; combinational.
- `busy`  out  1  divide in progress.
- `done`  out  1  one-cycle pulse after a divide result is written.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE, internal counter/operands 0.
- States: IDLE, DIV, FIX.
- IDLE, rising edge, priority order:
  - `start` with MULT/MULTU: `{hi,lo}` ← 64-bit signed/unsigned product; stay IDLE.
  - `start` with DIV/DIVU: latch |dataA|, |dataB| (raw values for DIVU), sign of quotient (sA^sB) and sign of remainder (sA); clear partial remainder; count=0; go to DIV.
  - `mthi` → `hi` ← `dataA`; `mtlo` → `lo` ← `dataA`. Both may occur in the same cycle. `start` wins over mthi/mtlo.
  - `start` with any other func: ignored.
- DIV: one restoring step per cycle:
  - rem ← {rem[31:0], dividend msb}; shift dividend left.
  - If rem ≥ divisor: subtract and set quotient bit.
  - count increments; after step 32 (count==31 at edge) go to FIX.
  - Remainder datapath is 33 bits wide.
- FIX: write results, go to IDLE, pulse `done` the following cycle.
  - `lo` ← quotient, negated if quotient sign set (DIV only).
  - `hi` ← remainder, negated if remainder sign set (DIV only).
- Divide by zero, either sign: `lo`=0xFFFFFFFF, `hi`=`dataA` as latched (raw, unsigned-reinterpreted).
- Signed overflow 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- While `busy`: `start`, `mthi` and `mtlo` are ignored. Hazard control must stall any HI/LO-touching instruction while `busy`=1.
- `cancel`, any state: return to IDLE next edge; `hi`/`lo` unchanged; no `done`. `cancel` in IDLE also suppresses same-cycle `start`/`mthi`/`mtlo`.
- `reset` asserted mid-divide: immediate return to reset values, no result written.

## Timing
- MULT/MULTU/MTHI/MTLO: `start`/`mt*` sampled at edge N; new `hi`/`lo` visible after edge N; `busy` never asserted.
- DIV/DIVU: `start` sampled at edge N.
  - `busy`=1 after edge N through edge N+33.
  - Steps at edges N+1..N+32; FIX writes `hi`/`lo` at edge N+33.
  - `busy`=0 and `done`=1 after N+33; `done` returns to 0 after N+34.
- Back-to-back: a new `start` is accepted at edge N+34 (first IDLE edge).
- `mf_result` has zero latency relative to `hi`/`lo`; no internal forwarding of in-flight results.

## Test plan
- Reset, then MULT dataA=0xFFFFFFFE (-2), dataB=3 → after 1 edge `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `busy` stays 0. MULTU with same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV dataA=-7 (0xFFFFFFF9), dataB=2 → `busy` high exactly 33 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `done` one cycle. DIVU 100/7 → `lo`=14, `hi`=2.
- DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- During a divide, pulse `mthi` dataA=0x1234 and `start` MULT → both ignored; final `hi`/`lo` equal the divide result only.
- `cancel` at DIV step 10 → IDLE next edge, `hi`/`lo` keep pre-divide values (e.g. 0xAAAA/0x5555), no `done`. Repeat with async `reset` at step 20 → all outputs 0 immediately.
- MTHI 0xDEADBEEF and MTLO same cycle, then `mfhi`=1 → `mf_result`=0xDEADBEEF; `mflo`=1 → same. Then MULT `start` with `mtlo` same cycle → product written, `mtlo` ignored.
